datapath: RTL and testbench
===========================

Name: datapath

Overview:
- 16-bit execute datapath for the simple RISC CPU.
- Contains an 8×16 register file, pipeline registers A/B/C, a B-operand shifter, operand muxes, a 4-function ALU and a zero-status flag.
- Driven cycle by cycle by the controller FSM; the controller sequences fetch-A, fetch-B, execute, write-back.

Parameters:
- WIDTH, 16, data width; only 16 is supported.
- IMM_W, 5, width of the immediate taken from datapath_in when bsel=1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- readnum  in  3  register-file read address (combinational)
- vsel  in  1  write-back source: 1 = datapath_in, 0 = datapath_out
- loada  in  1  load register A from read data
- loadb  in  1  load register B from read data
- shift  in  2  B shifter control
- asel  in  1  1 = ALU A input forced to 0
- bsel  in  1  1 = ALU B input is zero-extended datapath_in[4:0]
- ALUop  in  2  ALU function select
- loadc  in  1  load C from ALU result
- loads  in  1  load Z status from ALU
- writenum  in  3  register-file write address
- write  in  1  register-file write enable
- datapath_in  in  16  immediate / external write data
- Z_out  out  1  zero status register
- datapath_out  out  16  register C contents

Behaviour:
- Single clock domain.
- rst_n low asynchronously clears R0–R7, A, B, C and Z; datapath_out=0 and Z_out=0 during reset.
- Register file
  - Instance REGFILE; registers are named R0..R7 and must be hierarchically accessible.
  - Read: read_data = R[readnum], purely combinational.
  - Write: on posedge clk with write=1, R[writenum] <= (vsel ? datapath_in : datapath_out). No write when write=0.
  - Read and write to the same register in one cycle: the read returns the old value until the edge.
- Pipeline registers A, B, C and Z
  - A <= read_data on posedge when loada=1; B <= read_data when loadb=1; otherwise they hold.
  - loada and loadb may both be 1; both then capture the same read_data.
- Shifter, applied to B (sout):
  - 00: B unchanged.
  - 01: B<<1, LSB=0.
  - 10: logical >>1, MSB=0.
  - 11: arithmetic >>1, MSB=B[15].
- Operand muxes:
  - Ain = asel ? 0 : A.
  - Bin = bsel ? {11'b0, datapath_in[4:0]} : sout.
- ALU (combinational, modulo 2^16, no carry out):
  - 00: Ain+Bin.
  - 01: Ain−Bin.
  - 10: Ain&Bin.
  - 11: ~Bin (Ain ignored).
- Result and status registers:
  - C <= ALU result on posedge when loadc=1; datapath_out = C.
  - Z <= (ALU result==0) on posedge when loads=1; Z_out = Z.
  - loadc and loads are independent of each other.
- Latency for a register-register operation:
  - A and B each take one edge to load.
  - Result appears on datapath_out one edge after loadc.
  - Write-back (vsel=0) takes one further edge.

Optional Feature:
- Macro STATUS_NV_EN.
- When defined:
  - Adds outputs N_out (1) and V_out (1), loaded with Z when loads=1.
  - N = result[15].
  - V = signed overflow, computed for ADD/SUB only and 0 for AND/MVN.
  - Both clear on reset.
- When undefined: ports are absent and only Z exists; all other behaviour is identical.

Test Plan:
- Write path: write R0=50 and R1=21 via vsel=1, write=1 → R0=50, R1=21 after the edge. A separate cycle with write=0 changes no register.
- Basic ALU ops with readnum/loada/loadb sequencing, then loadc/loads:
  - ADD R0,R1 → 71, Z=0.
  - SUB → 29, Z=0.
  - AND → 16, Z=0.
  - Write each back via vsel=0.
- Shifts with asel=1, ADD:
  - R2=71, shift 10 → 35.
  - ADD R2 + (R3=29 shift 01) → 129.
  - SUB R2 − (R4=35 shift 10) → 54.
  - SUB R6 − (R6 shift 01) → −54 (0xFFCA).
  - 0x8000 with shift 11 → 0xC000.
- Zero flag: SUB R6,R6 with no shift → datapath_out=0, Z_out=1.
- MVN and immediates:
  - R7=6, MVN with asel=1 → 0xFFF9, Z=0.
  - bsel=1, datapath_in=1, ADD → 0xFFFA (−6).
  - Then immediate 25 → 19.
- Reset: assert rst_n low mid-operation with nonzero registers → all R*, C=0 and Z=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath -- 16-bit execute datapath for the simple RISC CPU.
//
// An 8x16 register file feeds operand registers A and B. B passes through a
// one-bit shifter. The operand muxes then feed a 4-function ALU, and the
// result is captured in register C and the zero-status flag Z. Every enable
// is driven cycle by cycle by the controller FSM in this order:
// fetch-A, fetch-B, execute, write-back.
//
// Optional build macro:
//   STATUS_NV_EN  adds the N_out/V_out status flags (negative, signed overflow)
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   readnum        register-file read address (combinational read)
//   writenum,write register-file write address / enable
//   vsel           write-back source: 1 = datapath_in, 0 = datapath_out
//   loada, loadb   capture read data into A / B
//   shift          B shifter: 00 pass, 01 <<1, 10 logical >>1, 11 arith >>1
//   asel           1 = ALU A operand forced to zero
//   bsel           1 = ALU B operand is zero-extended datapath_in[IMM_W-1:0]
//   ALUop          00 add, 01 sub, 10 and, 11 not-B
//   loadc, loads   capture ALU result into C / zero flag into Z
//   datapath_in    immediate / external write data
//   Z_out          zero status register
//   datapath_out   contents of register C
//   N_out, V_out   negative / signed-overflow status (STATUS_NV_EN only)
// ---------------------------------------------------------------------------

// Register file: eight named registers R0..R7, combinational read,
// synchronous write. A read and a write to the same register in one cycle
// return the old value, because the new value only lands on the edge.
module datapath_regfile #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       readnum,
  input  logic [2:0]       writenum,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R0 <= '0;
      R1 <= '0;
      R2 <= '0;
      R3 <= '0;
      R4 <= '0;
      R5 <= '0;
      R6 <= '0;
      R7 <= '0;
    end else if (write) begin
      case (writenum)
        3'd0: R0 <= data_in;
        3'd1: R1 <= data_in;
        3'd2: R2 <= data_in;
        3'd3: R3 <= data_in;
        3'd4: R4 <= data_in;
        3'd5: R5 <= data_in;
        3'd6: R6 <= data_in;
        default: R7 <= data_in;
      endcase
    end
  end

  always_comb begin
    read_data = R0;
    case (readnum)
      3'd0: read_data = R0;
      3'd1: read_data = R1;
      3'd2: read_data = R2;
      3'd3: read_data = R3;
      3'd4: read_data = R4;
      3'd5: read_data = R5;
      3'd6: read_data = R6;
      default: read_data = R7;
    endcase
  end

endmodule

module datapath #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       readnum,
  input  logic             vsel,
  input  logic             loada,
  input  logic             loadb,
  input  logic [1:0]       shift,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       ALUop,
  input  logic             loadc,
  input  logic             loads,
  input  logic [2:0]       writenum,
  input  logic             write,
  input  logic [WIDTH-1:0] datapath_in,
  output logic             Z_out,
  output logic [WIDTH-1:0] datapath_out
`ifdef STATUS_NV_EN
  ,
  output logic             N_out,
  output logic             V_out
`endif
);

  logic [WIDTH-1:0]        read_data;
  logic [WIDTH-1:0]        wb_data;
  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic signed [WIDTH-1:0] sout, ain, bin, alu_res;
  logic signed [WIDTH-1:0] c_p1;
  logic                    z_p1;

  // Signed overflow for add/sub: the operand signs predict the result sign,
  // and a mismatch means the true result did not fit. Logic ops never
  // overflow.
  function automatic logic ovf_flag(input logic [1:0] op,
                                    input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r);
    logic sa, sb, sr;
    sa = a[WIDTH-1];
    sb = b[WIDTH-1];
    sr = r[WIDTH-1];
    case (op)
      2'b00:   ovf_flag = (sa == sb) && (sr != sa);
      2'b01:   ovf_flag = (sa != sb) && (sr != sa);
      default: ovf_flag = 1'b0;
    endcase
  endfunction

  assign wb_data = vsel ? datapath_in : datapath_out;

  datapath_regfile #(.WIDTH(WIDTH)) REGFILE (
    .clk       (clk),
    .rst_n     (rst_n),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .data_in   (wb_data),
    .read_data (read_data)
  );

  // ---- stage p0: operand fetch into A and B ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0 <= '0;
      b_p0 <= '0;
    end else begin
      if (loada) a_p0 <= read_data;
      if (loadb) b_p0 <= read_data;
    end
  end

  always_comb begin
    sout = b_p0;
    case (shift)
      2'b00: sout = b_p0;
      2'b01: sout = {b_p0[WIDTH-2:0], 1'b0};
      2'b10: sout = {1'b0, b_p0[WIDTH-1:1]};
      2'b11: sout = {b_p0[WIDTH-1], b_p0[WIDTH-1:1]};
    endcase
  end

  assign ain = asel ? '0 : a_p0;
  assign bin = bsel ? {{(WIDTH-IMM_W){1'b0}}, datapath_in[IMM_W-1:0]} : sout;

  always_comb begin
    alu_res = '0;
    case (ALUop)
      2'b00: alu_res = ain + bin;
      2'b01: alu_res = ain - bin;
      2'b10: alu_res = ain & bin;
      2'b11: alu_res = ~bin;
    endcase
  end

  // ---- stage p1: result register C and status flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_p1 <= '0;
      z_p1 <= 1'b0;
    end else begin
      if (loadc) c_p1 <= alu_res;
      if (loads) z_p1 <= (alu_res == '0);
    end
  end

  assign datapath_out = c_p1;
  assign Z_out        = z_p1;

`ifdef STATUS_NV_EN
  logic n_p1, v_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_p1 <= 1'b0;
      v_p1 <= 1'b0;
    end else if (loads) begin
      n_p1 <= alu_res[WIDTH-1];
      v_p1 <= ovf_flag(ALUop, ain, bin, alu_res);
    end
  end

  assign N_out = n_p1;
  assign V_out = v_p1;
`else
  // Without the optional flags the overflow helper has no consumer; fold it
  // into a dummy signal so the function stays compiled in both builds.
  logic ovf_unused;
  assign ovf_unused = ovf_flag(ALUop, ain, bin, alu_res);
`endif

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  readnum, writenum;
  logic        vsel, loada, loadb, asel, bsel, loadc, loads, write;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;
  logic        Z_out;
  logic [15:0] datapath_out;
`ifdef STATUS_NV_EN
  logic        N_out, V_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  datapath dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .readnum      (readnum),
    .vsel         (vsel),
    .loada        (loada),
    .loadb        (loadb),
    .shift        (shift),
    .asel         (asel),
    .bsel         (bsel),
    .ALUop        (ALUop),
    .loadc        (loadc),
    .loads        (loads),
    .writenum     (writenum),
    .write        (write),
    .datapath_in  (datapath_in),
    .Z_out        (Z_out),
    .datapath_out (datapath_out)
`ifdef STATUS_NV_EN
    ,
    .N_out        (N_out),
    .V_out        (V_out)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    readnum = 0; writenum = 0; vsel = 0; loada = 0; loadb = 0;
    asel = 0; bsel = 0; loadc = 0; loads = 0; write = 0;
    shift = 2'b00; ALUop = 2'b00; datapath_in = 16'h0;
  endtask

  task automatic wr_imm(input logic [2:0] n, input logic [15:0] val);
    vsel = 1; write = 1; writenum = n; datapath_in = val;
    step();
    write = 0; vsel = 0;
  endtask

  task automatic load_a(input logic [2:0] n);
    readnum = n; loada = 1;
    step();
    loada = 0;
  endtask

  task automatic load_b(input logic [2:0] n);
    readnum = n; loadb = 1;
    step();
    loadb = 0;
  endtask

  task automatic exec(input logic [1:0] sh, input logic as, input logic bs,
                      input logic [1:0] op, input logic [15:0] imm, input logic ls);
    shift = sh; asel = as; bsel = bs; ALUop = op; datapath_in = imm;
    loadc = 1; loads = ls;
    step();
    loadc = 0; loads = 0;
  endtask

  task automatic wb(input logic [2:0] n);
    vsel = 0; write = 1; writenum = n;
    step();
    write = 0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    check("reset_out", datapath_out, 16'h0);
    check("reset_z", {15'b0, Z_out}, 16'h0);
    check("reset_r0", dut.REGFILE.R0, 16'h0);
    rst_n = 1'b1;
    step();

    // Write path
    wr_imm(3'd0, 16'd50);
    wr_imm(3'd1, 16'd21);
    check("wr_r0", dut.REGFILE.R0, 16'd50);
    check("wr_r1", dut.REGFILE.R1, 16'd21);
    vsel = 1; write = 0; writenum = 3'd0; datapath_in = 16'd999;
    step();
    check("nowrite_r0", dut.REGFILE.R0, 16'd50);

    // Basic ALU ops, A=R0=50, B=R1=21
    load_a(3'd0);
    load_b(3'd1);
    exec(2'b00, 0, 0, 2'b00, 16'h0, 1);
    check("add", datapath_out, 16'd71);
    check("add_z", {15'b0, Z_out}, 16'h0);
    wb(3'd2);
    check("wb_r2", dut.REGFILE.R2, 16'd71);
    exec(2'b00, 0, 0, 2'b01, 16'h0, 1);
    check("sub", datapath_out, 16'd29);
    wb(3'd3);
    exec(2'b00, 0, 0, 2'b10, 16'h0, 1);
    check("and", datapath_out, 16'd16);
    check("and_z", {15'b0, Z_out}, 16'h0);
    wb(3'd5);
    check("wb_r5", dut.REGFILE.R5, 16'd16);

    // Shifts
    load_b(3'd2);
    exec(2'b10, 1, 0, 2'b00, 16'h0, 1);
    check("shr_71", datapath_out, 16'd35);
    wb(3'd4);
    load_a(3'd2);
    load_b(3'd3);
    exec(2'b01, 0, 0, 2'b00, 16'h0, 1);
    check("add_shl", datapath_out, 16'd129);
    load_a(3'd2);
    load_b(3'd4);
    exec(2'b10, 0, 0, 2'b01, 16'h0, 1);
    check("sub_shr", datapath_out, 16'd54);
    wb(3'd6);
    load_a(3'd6);
    load_b(3'd6);
    exec(2'b01, 0, 0, 2'b01, 16'h0, 1);
    check("sub_neg", datapath_out, 16'hFFCA);
    check("sub_neg_z", {15'b0, Z_out}, 16'h0);

    // Zero flag
    exec(2'b00, 0, 0, 2'b01, 16'h0, 1);
    check("zero_out", datapath_out, 16'h0);
    check("zero_z", {15'b0, Z_out}, 16'h1);
    // loadc without loads leaves Z alone
    exec(2'b01, 0, 0, 2'b00, 16'h0, 0);
    check("c_only", datapath_out, 16'd162);
    check("z_hold", {15'b0, Z_out}, 16'h1);

    // Arithmetic shift right of 0x8000
    wr_imm(3'd7, 16'h8000);
    load_b(3'd7);
    exec(2'b11, 1, 0, 2'b00, 16'h0, 1);
    check("asr", datapath_out, 16'hC000);
    check("asr_z", {15'b0, Z_out}, 16'h0);

    // MVN and immediates
    wr_imm(3'd7, 16'd6);
    load_b(3'd7);
    exec(2'b00, 1, 0, 2'b11, 16'h0, 1);
    check("mvn", datapath_out, 16'hFFF9);
    check("mvn_z", {15'b0, Z_out}, 16'h0);
    wb(3'd1);
    load_a(3'd1);
    exec(2'b00, 0, 1, 2'b00, 16'd1, 1);
    check("imm1", datapath_out, 16'hFFFA);
    wb(3'd1);
    load_a(3'd1);
    exec(2'b00, 0, 1, 2'b00, 16'd25, 1);
    check("imm25", datapath_out, 16'd19);
    // Only the low 5 bits of datapath_in are the immediate
    exec(2'b00, 0, 1, 2'b00, 16'hFFE3, 1);
    check("imm_mask", datapath_out, 16'hFFFD);

    // Read and write of R0 in one cycle: A captures the old value
    readnum = 3'd0; loada = 1; vsel = 1; write = 1; writenum = 3'd0;
    datapath_in = 16'h1234;
    step();
    loada = 0; write = 0;
    check("rw_new_r0", dut.REGFILE.R0, 16'h1234);
    exec(2'b00, 0, 1, 2'b00, 16'h0, 1);
    check("rw_old_a", datapath_out, 16'd50);

    // Asynchronous reset mid-operation
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out", datapath_out, 16'h0);
    check("arst_z", {15'b0, Z_out}, 16'h0);
    check("arst_r0", dut.REGFILE.R0, 16'h0);
    check("arst_r1", dut.REGFILE.R1, 16'h0);
    check("arst_r2", dut.REGFILE.R2, 16'h0);
    check("arst_r6", dut.REGFILE.R6, 16'h0);
    check("arst_r7", dut.REGFILE.R7, 16'h0);
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
